window3x3_stream: RTL

- Upstream neighbour of the 3x3 Gaussian stage. Converts a raster pixel stream (one pixel per beat, valid/ready) into one 3x3 neighbourhood window per output beat.
- Output is centred on each image pixel, with zero padding outside the image.
- The Gaussian/convolution stage consumes the windows directly. It no longer needs whole-row buses or a full-frame line buffer.

---
 rtl/img_pkg.sv | 14 +
 rtl/line_buffer.sv | 23 ++
 rtl/window3x3_stream.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the image-processing stream blocks (window builder,
// Gaussian stage).
package img_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    // Bit offset of window tap (r,c) inside a packed 3x3 window; r=0 is the row above.
    function automatic int tap_lsb(input int r, input int c, input int width);
        return (3 * r + c) * width;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-row delay memory: combinational read of the old word, write at the
// clock edge, so a same-address access returns the previous row's pixel.
module line_buffer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/window3x3_stream.sv
// Raster pixel stream to zero-padded 3x3 neighbourhood windows, one window per
// output beat, centred on every image pixel.
module window3x3_stream
    import img_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_pixel,
    input  logic                       in_sof,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [9*WIDTH-1:0]         out_window,
    output logic [$clog2(IMG_W)-1:0]   out_x,
    output logic [$clog2(IMG_H)-1:0]   out_y,
    output logic                       out_last,
    output logic                       err
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t state, state_nxt;
    logic [XW-1:0] in_x, cx;
    logic [YW-1:0] in_y, cy;
    logic accept, free, restart, step, load;
    logic [WIDTH-1:0] pix, lb1_rd, lb2_rd;
    logic [WIDTH-1:0] win_p0  [3][3];
    logic [WIDTH-1:0] win_nxt [3][3];
    logic [9*WIDTH-1:0] window_pad;

    function automatic logic [WIDTH-1:0] pad_tap(input logic [WIDTH-1:0] px, input int r, input int c,
                                                 input logic top, input logic bot,
                                                 input logic left, input logic right);
        if ((r == 0 && top) || (r == 2 && bot) || (c == 0 && left) || (c == 2 && right))
            return '0;
        return px;
    endfunction

    assign free     = !out_valid || out_ready;
    assign in_ready = (state != FLUSH) && free;
    assign accept   = in_valid && in_ready;
    assign restart  = accept && in_sof && !(in_x == '0 && in_y == '0);
    // FLUSH pushes virtual zero pixels through the same path to finish the last rows.
    assign step     = accept || (state == FLUSH && free);
    assign load     = step && !restart && (state != FILL);
    assign pix      = (state == FLUSH) ? '0 : in_pixel;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH)) u_lb1 (
        .clk(clk), .we(step), .addr(restart ? '0 : in_x), .wdata(pix), .rdata(lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH)) u_lb2 (
        .clk(clk), .we(step), .addr(restart ? '0 : in_x), .wdata(lb1_rd), .rdata(lb2_rd)
    );

    // Stage p0: column shift; the window always sits in the post-shift array.
    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                win_nxt[r][c] = win_p0[r][c+1];
        win_nxt[0][2] = lb2_rd;
        win_nxt[1][2] = lb1_rd;
        win_nxt[2][2] = pix;
    end

    always_ff @(posedge clk) begin
        if (step) win_p0 <= win_nxt;
    end

    always_comb begin
        window_pad = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                window_pad[tap_lsb(r, c, WIDTH) +: WIDTH] =
                    pad_tap(win_nxt[r][c], r, c, cy == '0, cy == Y_LAST, cx == '0, cx == X_LAST);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:  if (accept && in_x == '0 && in_y == YW'(1)) state_nxt = RUN;
            RUN:   if (accept && in_x == X_LAST && in_y == Y_LAST) state_nxt = FLUSH;
            FLUSH: if (load && cx == X_LAST && cy == Y_LAST) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
        if (restart) state_nxt = FILL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
            in_x  <= '0;
            in_y  <= '0;
            cx    <= '0;
            cy    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                err  <= 1'b1;
                in_x <= XW'(1);
                in_y <= '0;
                cx   <= '0;
                cy   <= '0;
            end else begin
                if (step) begin
                    if (state == FLUSH && state_nxt == FILL)
                        in_x <= '0;
                    else
                        in_x <= (in_x == X_LAST) ? '0 : in_x + 1'b1;
                    if (state != FLUSH && in_x == X_LAST)
                        in_y <= (in_y == Y_LAST) ? '0 : in_y + 1'b1;
                end
                if (load) begin
                    cx <= (cx == X_LAST) ? '0 : cx + 1'b1;
                    if (cx == X_LAST) cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
                end
            end
        end
    end

    // Stage p1: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_window <= window_pad;
            out_x      <= cx;
            out_y      <= cy;
            out_last   <= (cx == X_LAST) && (cy == Y_LAST);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
